// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a FIFO of queued bytes feeding a start/data/stop
// serializer that drives the HC-05 RX line back-to-back at the configured baud rate.
module uart_tx_fifo #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    state_t           state_next;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             push;
    logic             pop;
    logic             bit_end;

    assign tx_ready = (fifo_count != FULL_COUNT);
    assign push     = tx_valid && tx_ready;
    assign bit_end  = (baud_cnt == BIT_LAST);
    assign tx_busy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= tx_data;
    end

    // A simultaneous push and pop leaves the count untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    state_next = START;
                    pop        = 1'b1;
                end
            end
            START: begin
                if (bit_end)
                    state_next = DATA;
            end
            DATA: begin
                if (bit_end && bit_idx == 3'd7)
                    state_next = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (fifo_count != '0) begin
                        state_next = START;
                        pop        = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line driver and shifter; the stop-to-start handoff reloads without an idle gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            uart_tx   <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            tx_done  <= (state == STOP) && bit_end;
            baud_cnt <= (state == IDLE || bit_end) ? '0 : baud_cnt + CNT_W'(1);
            if (pop) begin
                shift_reg <= mem[rd_ptr];
                uart_tx   <= 1'b0;
            end else begin
                unique case (state)
                    START: begin
                        if (bit_end) begin
                            uart_tx <= shift_reg[0];
                            bit_idx <= '0;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            if (bit_idx == 3'd7) begin
                                uart_tx <= 1'b1;
                            end else begin
                                uart_tx   <= shift_reg[1];
                                shift_reg <= shift_reg >> 1;
                                bit_idx   <= bit_idx + 3'd1;
                            end
                        end
                    end
                    default: uart_tx <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-and-timeline model of the line is compared every
// cycle, a monitor decodes frames, and a default-parameter instance checks real baud timing.
module tb_uart_tx_fifo;

    localparam int CPB   = 10;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, uart_tx, tx_busy, tx_done;
    logic [4:0] fifo_count;

    logic [7:0] tx_data2 = 8'h00;
    logic       tx_valid2 = 1'b0;
    logic       tx_ready2, uart_tx2, tx_busy2, tx_done2;
    logic [4:0] fifo_count2;

    int checks = 0;
    int fails  = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .uart_tx(uart_tx), .tx_busy(tx_busy),
        .tx_done(tx_done), .fifo_count(fifo_count)
    );

    uart_tx_fifo dut_default (
        .clk(clk), .reset(reset), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .uart_tx(uart_tx2), .tx_busy(tx_busy2),
        .tx_done(tx_done2), .fifo_count(fifo_count2)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: bytes wait in a queue; an active frame is a byte plus elapsed cycles.
    logic [7:0] m_q[$];
    bit         m_active;
    int         m_t;
    logic [7:0] m_cur;
    bit         m_done;
    bit         m_push;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_active = 1'b0;
            m_t      = 0;
            m_done   = 1'b0;
        end else begin
            m_push = tx_valid && (m_q.size() != DEPTH);
            m_done = 1'b0;
            if (m_active) begin
                m_t++;
                if (m_t == FRAME) begin
                    m_done   = 1'b1;
                    m_active = 1'b0;
                end
            end
            if (!m_active && m_q.size() != 0) begin
                m_cur    = m_q.pop_front();
                m_active = 1'b1;
                m_t      = 0;
            end
            if (m_push)
                m_q.push_back(tx_data);
        end
    end

    function automatic int expLine();
        int b;
        if (!m_active)
            return 1;
        b = m_t / CPB;
        if (b == 0)
            return 0;
        if (b <= 8)
            return int'(m_cur[b-1]);
        return 1;
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("uart_tx", uart_tx, expLine());
            checkOutput("tx_busy", tx_busy, int'(m_active));
            checkOutput("tx_done", tx_done, int'(m_done));
            checkOutput("fifo_count", fifo_count, m_q.size());
            checkOutput("tx_ready", tx_ready, int'(m_q.size() != DEPTH));
        end
    end

    // Frame decoder sampling mid-bit, plus tx_done bookkeeping.
    int         cyc = 0;
    bit         mon_in = 1'b0;
    int         mon_start, off, bi;
    logic [7:0] mon_byte;
    logic [7:0] decoded[$];
    int         done_cnt = 0;
    int         last_fall = 0;
    int         last_done = 0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            mon_in = 1'b0;
        end else begin
            if (!mon_in && uart_tx == 1'b0) begin
                mon_in    = 1'b1;
                mon_start = cyc;
                last_fall = cyc;
            end else if (mon_in) begin
                off = cyc - mon_start;
                bi  = off / CPB;
                if (off % CPB == CPB / 2 && bi >= 1 && bi <= 8)
                    mon_byte[bi-1] = uart_tx;
                if (off == 9 * CPB + CPB / 2) begin
                    checkOutput("stop_bit", uart_tx, 1);
                    decoded.push_back(mon_byte);
                    mon_in = 1'b0;
                end
            end
            if (tx_done) begin
                done_cnt++;
                last_done = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d);
        int guard;
        bit taken;
        guard = 0;
        taken = 1'b0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!taken && guard < 2000) begin
            taken = tx_ready;
            tick(1);
            guard++;
        end
        tx_valid = 1'b0;
        checkOutput("push_accepted", int'(taken), 1);
    endtask

    task automatic waitDone(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput("done_count", done_cnt, target);
    endtask

    int f0, accepted, n;
    bit was_ready;
    logic [7:0] exp_bytes[$];

    initial begin
        #1 reset = 1'b1;
        check_en = 1'b1;
        tick(3);
        checkOutput("rst_uart_tx", uart_tx, 1);
        checkOutput("rst_tx_ready", tx_ready, 1);
        checkOutput("rst_tx_busy", tx_busy, 0);
        checkOutput("rst_tx_done", tx_done, 0);
        checkOutput("rst_fifo_count", fifo_count, 0);
        reset = 1'b0;
        tick(200);
        checkOutput("idle_frames", decoded.size(), 0);
        checkOutput("idle_done", done_cnt, 0);

        $display("[TB] single byte 0x55");
        applyStimulus(8'h55);
        waitDone(1, 150);
        checkOutput("single_len", last_done - last_fall, FRAME);
        checkOutput("single_byte", decoded.size() == 1 ? int'(decoded[0]) : -1, 'h55);
        tick(20);
        checkOutput("single_busy", tx_busy, 0);
        checkOutput("single_done_once", done_cnt, 1);

        $display("[TB] burst A5 00 FF");
        decoded.delete();
        done_cnt = 0;
        applyStimulus(8'hA5);
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        f0 = last_fall;
        waitDone(3, 400);
        checkOutput("burst_len", last_done - f0, 3 * FRAME);
        checkOutput("burst_count", decoded.size(), 3);
        if (decoded.size() == 3) begin
            checkOutput("burst_b0", decoded[0], 'hA5);
            checkOutput("burst_b1", decoded[1], 'h00);
            checkOutput("burst_b2", decoded[2], 'hFF);
        end
        tick(20);

        $display("[TB] full fifo");
        decoded.delete();
        exp_bytes.delete();
        done_cnt = 0;
        accepted = 0;
        tx_data  = 8'h30;
        tx_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            was_ready = tx_ready;
            tick(1);
            if (was_ready) begin
                exp_bytes.push_back(tx_data);
                accepted++;
                if (accepted < 20)
                    tx_data = 8'h30 + 8'(accepted);
            end
        end
        tx_valid = 1'b0;
        checkOutput("full_accepted", accepted, 17);
        checkOutput("full_count", fifo_count, 16);
        checkOutput("full_ready", tx_ready, 0);
        waitDone(1, 150);
        checkOutput("full_ready_back", tx_ready, 1);
        checkOutput("full_count_after", fifo_count, 15);
        waitDone(17, 1900);
        checkOutput("full_decoded", decoded.size(), 17);
        for (int i = 0; i < 17; i++)
            if (i < decoded.size() && i < exp_bytes.size())
                checkOutput($sformatf("full_byte%0d", i), decoded[i], exp_bytes[i]);
        tick(20);

        $display("[TB] reset mid-frame");
        decoded.delete();
        done_cnt = 0;
        applyStimulus(8'h0F);
        tick(44);
        checkOutput("mid_low_bit3", uart_tx, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_uart_tx", uart_tx, 1);
        checkOutput("mid_fifo_count", fifo_count, 0);
        checkOutput("mid_busy", tx_busy, 0);
        tick(2);
        reset = 1'b0;
        tick(200);
        checkOutput("mid_no_frames", decoded.size(), 0);
        checkOutput("mid_no_done", done_cnt, 0);

        $display("[TB] default parameters 0x80");
        check_en  = 1'b0;
        tx_data2  = 8'h80;
        tx_valid2 = 1'b1;
        tick(1);
        tx_valid2 = 1'b0;
        n = 0;
        while (uart_tx2 && n < 5) begin
            tick(1);
            n++;
        end
        checkOutput("def_fall", uart_tx2, 0);
        checkOutput("def_busy", tx_busy2, 1);
        checkOutput("def_count", fifo_count2, 0);
        n = 0;
        while (!uart_tx2 && n < 60000) begin
            tick(1);
            n++;
        end
        checkOutput("def_low_span", n, 8 * 5208);
        while (!tx_done2 && n < 60000) begin
            tick(1);
            n++;
        end
        checkOutput("def_frame", n, 52080);
        tick(2);
        checkOutput("def_idle", tx_busy2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
